// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
//   NUM_ROWS / NUM_COLS : matrix geometry
//   key_vec_t           : one pressed-key snapshot, bit index = 4*col + row
//   scan_state_t        : scanner FSM states
//   is_ghosted()        : rectangle test used when KEYPAD_GHOST_REJECT_EN is defined
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    typedef logic [NUM_ROWS*NUM_COLS-1:0] key_vec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        SAMPLE  = 2'd2,
        PUBLISH = 2'd3
    } scan_state_t;

    // Ghosted when two distinct columns share at least two pressed rows.
    function automatic logic is_ghosted(input key_vec_t k);
        logic                hit;
        logic [NUM_ROWS-1:0] common;
        hit = 1'b0;
        for (int unsigned c1 = 0; c1 < NUM_COLS; c1++) begin
            for (int unsigned c2 = c1 + 1; c2 < NUM_COLS; c2++) begin
                common = k[c1*NUM_ROWS +: NUM_ROWS] & k[c2*NUM_ROWS +: NUM_ROWS];
                if ($countones(common) > 1) hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer with synchronous active-low reset to all-ones.
//   clk   : destination clock
//   reset : synchronous, active-low
//   d     : asynchronous input
//   q     : synchronized output, two cycles of latency
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, samples
// the synchronized rows, and publishes a full-frame snapshot atomically.
//   clk          : system clock
//   reset        : synchronous, active-low
//   row_n[3:0]   : asynchronous row lines, 0 = pressed in driven column
//   col_n[3:0]   : active-low one-hot column drive, 4'b1111 = none
//   keys_pressed : last complete frame, bit 4*col+row
//   scan_done    : one-cycle pulse when a frame is published
//   ghost        : last frame rejected as ghosted
// Optional: define KEYPAD_GHOST_REJECT_EN to enable ghost rejection; otherwise
// ghost is tied 0 and every frame is published.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [15:0] keys_pressed,
    output logic        scan_done,
    output logic        ghost
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned COL_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("keypad_scanner: SETTLE_CYCLES must be in 3..255");
    end

    scan_state_t          state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    key_vec_t             frame_buf_q, frame_buf_d;
    key_vec_t             keys_q, keys_d;
    logic [NUM_COLS-1:0]  col_n_q, col_n_d;
    logic                 scan_done_q, scan_done_d;
    logic [NUM_ROWS-1:0]  row_sync;

    sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (row_sync)
    );

`ifdef KEYPAD_GHOST_REJECT_EN
    logic ghost_q, ghost_d;
`endif

    // Next-state, frame assembly and registered-output computation.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        frame_buf_d = frame_buf_q;
        keys_d      = keys_q;
        scan_done_d = 1'b0;
`ifdef KEYPAD_GHOST_REJECT_EN
        ghost_d     = ghost_q;
`endif
        unique case (state_q)
            IDLE: begin
                state_d = DRIVE;
                col_d   = '0;
                cnt_d   = '0;
            end
            DRIVE: begin
                if (cnt_q == CNT_LAST) state_d = SAMPLE;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            SAMPLE: begin
                frame_buf_d[NUM_ROWS*32'(col_q) +: NUM_ROWS] = ~row_sync;
                if (col_q == COL_LAST) begin
                    state_d = PUBLISH;
                end else begin
                    state_d = DRIVE;
                    col_d   = col_q + COL_W'(1);
                    cnt_d   = '0;
                end
            end
            PUBLISH: begin
                scan_done_d = 1'b1;
`ifdef KEYPAD_GHOST_REJECT_EN
                if (is_ghosted(frame_buf_q)) begin
                    ghost_d = 1'b1;
                end else begin
                    ghost_d = 1'b0;
                    keys_d  = frame_buf_q;
                end
`else
                keys_d = frame_buf_q;
`endif
                state_d = DRIVE;
                col_d   = '0;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        // Column drive follows the state being entered so it is registered.
        if (state_d == IDLE) col_n_d = '1;
        else                 col_n_d = ~(NUM_COLS'(1) << col_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            cnt_q       <= '0;
            frame_buf_q <= '0;
            keys_q      <= '0;
            col_n_q     <= '1;
            scan_done_q <= 1'b0;
`ifdef KEYPAD_GHOST_REJECT_EN
            ghost_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            frame_buf_q <= frame_buf_d;
            keys_q      <= keys_d;
            col_n_q     <= col_n_d;
            scan_done_q <= scan_done_d;
`ifdef KEYPAD_GHOST_REJECT_EN
            ghost_q     <= ghost_d;
`endif
        end
    end

    assign col_n        = col_n_q;
    assign keys_pressed = keys_q;
    assign scan_done    = scan_done_q;
`ifdef KEYPAD_GHOST_REJECT_EN
    assign ghost        = ghost_q;
`else
    assign ghost        = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SETTLE_CYCLES=4 (column 5 cycles, frame 21).
module tb_keypad_scanner;

    localparam int unsigned FRAME = 21;

    logic        clk;
    logic        reset;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keys_pressed;
    logic        scan_done;
    logic        ghost;
    logic [15:0] pressed;

    int errors = 0;
    int checks = 0;

    keypad_scanner #(.SETTLE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .row_n        (row_n),
        .col_n        (col_n),
        .keys_pressed (keys_pressed),
        .scan_done    (scan_done),
        .ghost        (ghost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a driven column pulls pressed rows low.
    always_comb begin
        case (col_n)
            4'b1110: row_n = ~pressed[3:0];
            4'b1101: row_n = ~pressed[7:4];
            4'b1011: row_n = ~pressed[11:8];
            4'b0111: row_n = ~pressed[15:12];
            default: row_n = 4'b1111;
        endcase
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rect(input logic [15:0] v);
        for (int r1 = 0; r1 < 4; r1++)
            for (int r2 = r1 + 1; r2 < 4; r2++)
                for (int c1 = 0; c1 < 4; c1++)
                    for (int c2 = c1 + 1; c2 < 4; c2++)
                        if (v[4*c1+r1] && v[4*c1+r2] && v[4*c2+r1] && v[4*c2+r2])
                            return 1'b1;
        return 1'b0;
    endfunction

    // Behavioural model: position k in the scan since the release edge decides
    // the driven column; each column's rows are those pressed 3 cycles after
    // the column starts driving (2-flop synchronizer plus settle).
    initial begin : model
        int          k;
        int          p;
        int          c;
        logic        rst_at_edge;
        logic        next_rst;
        logic [3:0]  col_tab [4];
        logic [15:0] m_frame;
        logic [15:0] m_keys;
        logic        m_ghost;
        logic        exp_sd;
        col_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        k        = -1;
        m_frame  = '0;
        m_keys   = '0;
        m_ghost  = 1'b0;
        next_rst = 1'b0;
        forever begin
            @(negedge clk);
            rst_at_edge = next_rst;
            next_rst    = reset;
            if (!rst_at_edge) begin
                k       = -1;
                m_keys  = '0;
                m_ghost = 1'b0;
                m_frame = '0;
                chk("m_rst_col_n", {12'h0, col_n}, 16'h000f);
                chk("m_rst_keys", keys_pressed, 16'h0000);
                chk("m_rst_done", {15'h0, scan_done}, 16'h0000);
                chk("m_rst_ghost", {15'h0, ghost}, 16'h0000);
            end else begin
                k++;
                p      = k % FRAME;
                c      = (p < 20) ? p / 5 : 3;
                exp_sd = (k >= FRAME) && (p == 0);
                if (exp_sd) begin
`ifdef KEYPAD_GHOST_REJECT_EN
                    if (rect(m_frame)) m_ghost = 1'b1;
                    else begin m_ghost = 1'b0; m_keys = m_frame; end
`else
                    m_keys = m_frame;
`endif
                end
                chk("m_col_n", {12'h0, col_n}, {12'h0, col_tab[c]});
                chk("m_scan_done", {15'h0, scan_done}, {15'h0, exp_sd});
                chk("m_keys", keys_pressed, m_keys);
                chk("m_ghost", {15'h0, ghost}, {15'h0, m_ghost});
                if ((p % 5) == 2 && p < 20) m_frame[4*(p/5) +: 4] = pressed[4*(p/5) +: 4];
            end
        end
    end

    // Posedges until scan_done is seen at the following negedge.
    task automatic wait_sd(output int n);
        n = 0;
        while (1) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (scan_done) break;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL wait_sd: no scan_done within %0d cycles", n);
                break;
            end
        end
    endtask

    task automatic set_inputs(input logic rst, input logic [15:0] keys);
        @(posedge clk);
        #1;
        reset   = rst;
        pressed = keys;
    endtask

    task automatic wait_col(input logic [3:0] target);
        int n;
        n = 0;
        while (col_n !== target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_col", {12'h0, col_n}, {12'h0, target});
    endtask

    initial begin : stim
        int          n;
        int          pos;
        logic [3:0]  exp_col;
        reset   = 1'b0;
        pressed = 16'h0000;

        // 1: reset held, then released; column sequence
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_rst_col_n", {12'h0, col_n}, 16'h000f);
        chk("t1_rst_keys", keys_pressed, 16'h0000);
        set_inputs(1'b1, 16'h0000);
        @(posedge clk);
        for (int i = 0; i < 2*FRAME; i++) begin
            @(negedge clk);
            pos = i % FRAME;
            if (pos < 5)       exp_col = 4'b1110;
            else if (pos < 10) exp_col = 4'b1101;
            else if (pos < 15) exp_col = 4'b1011;
            else               exp_col = 4'b0111;
            chk("t1_col_seq", {12'h0, col_n}, {12'h0, exp_col});
        end

        // 2: col2/row1 held
        set_inputs(1'b1, 16'h0200);
        wait_sd(n);
        wait_sd(n);
        chk("t2_keys", keys_pressed, 16'h0200);
        wait_sd(n);
        chk("t2_period", 16'(n), 16'd21);
        chk("t2_keys_hold", keys_pressed, 16'h0200);
        @(negedge clk);
        chk("t2_pulse_1cyc", {15'h0, scan_done}, 16'h0000);

        // 3: two diagonal keys, then release
        set_inputs(1'b1, 16'h8001);
        wait_sd(n);
        wait_sd(n);
        chk("t3_keys", keys_pressed, 16'h8001);
        set_inputs(1'b1, 16'h0000);
        wait_sd(n);
        wait_sd(n);
        chk("t3_release", keys_pressed, 16'h0000);

        // 4: press col1/row2 while column 2 is driven
        wait_col(4'b1011);
        set_inputs(1'b1, 16'h0040);
        wait_sd(n);
        wait_sd(n);
        chk("t4_keys", keys_pressed, 16'h0040);

        // 5: reset mid-frame while column 2 is driven
        set_inputs(1'b1, 16'h0200);
        wait_sd(n);
        wait_sd(n);
        chk("t5_pre_keys", keys_pressed, 16'h0200);
        wait_col(4'b1011);
        set_inputs(1'b0, 16'h0200);
        @(posedge clk);
        @(negedge clk);
        chk("t5_rst_col_n", {12'h0, col_n}, 16'h000f);
        chk("t5_rst_keys", keys_pressed, 16'h0000);
        set_inputs(1'b1, 16'h0200);
        @(posedge clk);
        wait_sd(n);
        chk("t5_first_done", 16'(n), 16'd21);
        chk("t5_keys", keys_pressed, 16'h0200);

        // 6: ghost rectangle after a clean frame
        set_inputs(1'b1, 16'h0001);
        wait_sd(n);
        wait_sd(n);
        chk("t6_clean", keys_pressed, 16'h0001);
        set_inputs(1'b1, 16'h0033);
        wait_sd(n);
        wait_sd(n);
`ifdef KEYPAD_GHOST_REJECT_EN
        chk("t6_keys_held", keys_pressed, 16'h0001);
        chk("t6_ghost", {15'h0, ghost}, 16'h0001);
`else
        chk("t6_keys_raw", keys_pressed, 16'h0033);
        chk("t6_ghost", {15'h0, ghost}, 16'h0000);
`endif
        chk("t6_done", {15'h0, scan_done}, 16'h0001);
        set_inputs(1'b1, 16'h0001);
        wait_sd(n);
        wait_sd(n);
        chk("t6_recover", keys_pressed, 16'h0001);
        chk("t6_ghost_clr", {15'h0, ghost}, 16'h0000);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
